// File: rtl/fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_arbiter: shares a single-port framebuffer RAM between VGA scan-out and   |
// | host pixel writes. Display fetch always wins; writes fill the idle slots.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fb_arbiter #(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        active,
  input  logic        hs,
  input  logic        vs,
  input  logic        wr_vblank_only,
  input  logic        wr_valid,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pix_rgb,
  output logic        hs_o,
  output logic        vs_o,
  output logic        active_o,
  output logic        frame_tick,
  output logic [7:0]  wr_drop_cnt
);

  localparam logic [31:0] c_fb_size   = 32'(FB_W * FB_H);
  localparam logic [8:0]  c_vblank_y  = 9'd480;

  logic        w_fetch_slot;
  logic [14:0] w_fetch_addr;
  logic        w_wr_xfer;
  logic        w_wr_in_range;

  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        rd_q, rd_d;
  logic [7:0]  pix_q, pix_d;
  logic [2:0]  hs_pipe_q, hs_pipe_d;
  logic [2:0]  vs_pipe_q, vs_pipe_d;
  logic [2:0]  act_pipe_q, act_pipe_d;
  logic        vs_hist_q, vs_hist_d;
  logic        frame_tick_q, frame_tick_d;
  logic [7:0]  drop_q, drop_d;

  assign w_fetch_slot  = active && (x[SCALE_LOG2-1:0] == '0);
  assign w_fetch_addr  = 15'((32'(y) >> SCALE_LOG2) * FB_W + (32'(x) >> SCALE_LOG2));
  // Reset gates the handshake so a host write can never slip in while held.
  assign wr_ready      = rst_n && !w_fetch_slot && (!wr_vblank_only || (y >= c_vblank_y));
  assign w_wr_xfer     = wr_valid && wr_ready;
  assign w_wr_in_range = {17'd0, wr_addr} < c_fb_size;

  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    drop_d       = drop_q;
    if (w_fetch_slot) begin
      mem_en_d   = 1'b1;
      mem_addr_d = w_fetch_addr;
    end else if (w_wr_xfer) begin
      if (w_wr_in_range) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
    // RAM returns data the cycle after it sees the read; capture one edge later.
    rd_d         = mem_en_q && !mem_we_q;
    pix_d        = rd_q ? mem_rdata : pix_q;
    hs_pipe_d    = {hs_pipe_q[1:0], hs};
    vs_pipe_d    = {vs_pipe_q[1:0], vs};
    act_pipe_d   = {act_pipe_q[1:0], active};
    vs_hist_d    = vs;
    frame_tick_d = vs_hist_q && !vs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_q         <= 1'b0;
      pix_q        <= '0;
      hs_pipe_q    <= 3'b111;
      vs_pipe_q    <= 3'b111;
      act_pipe_q   <= 3'b000;
      vs_hist_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_q         <= rd_d;
      pix_q        <= pix_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      act_pipe_q   <= act_pipe_d;
      vs_hist_q    <= vs_hist_d;
      frame_tick_q <= frame_tick_d;
      drop_q       <= drop_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign hs_o        = hs_pipe_q[2];
  assign vs_o        = vs_pipe_q[2];
  assign active_o    = act_pipe_q[2];
  assign pix_rgb     = act_pipe_q[2] ? pix_q : 8'h00;
  assign frame_tick  = frame_tick_q;
  assign wr_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 Parameter SCALE_LOG2, default 2, log2 of the screen-to-framebuffer scale factor (4x4 screen pixels per framebuffer pixel).
REQ-004 clk  in  1  single system/pixel clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 x  in  10  current screen column from the VGA timing generator.
REQ-007 y  in  9  current screen line from the VGA timing generator.
REQ-008 active  in  1  visible-region flag from the timing generator.
REQ-009 hs, vs  in  1 each  sync from the timing generator, active-low.
REQ-010 wr_vblank_only  in  1  config: 1 = host writes granted only while y >= 480.
REQ-011 wr_valid  in  1  host write request.
REQ-012 wr_addr  in  15  host framebuffer address.
REQ-013 wr_data  in  8  host pixel, RGB332.
REQ-014 wr_ready  out  1  host write accept, combinational.
REQ-015 mem_en, mem_we  out  1 each  single-port framebuffer RAM enable / write enable, registered.
REQ-016 mem_addr  out  15; mem_wdata  out  8  RAM address / write data, registered.
REQ-017 mem_rdata  in  8  RAM read data, valid one cycle after a read is issued.
REQ-018 pix_rgb  out  8  pixel to DAC; hs_o, vs_o, active_o  out  1 each  delayed sync/active.
REQ-019 frame_tick  out  1  one-cycle pulse per frame.
REQ-020 wr_drop_cnt  out  8  count of dropped out-of-range writes, saturating.

Function
REQ-021 fetch_slot SHALL be defined as active && x[SCALE_LOG2-1:0] == 0, evaluated combinationally from current inputs.
REQ-022 Fetch address SHALL be (y >> SCALE_LOG2) * FB_W + (x >> SCALE_LOG2); range 0..19199 at defaults.
REQ-023 When fetch_slot is sampled at edge E0, the block SHALL drive mem_en=1, mem_we=0, mem_addr=fetch address during the cycle after E0.
REQ-024 The block SHALL capture mem_rdata into pix_rgb at E0+2 and hold it until the next capture.
REQ-025 hs_o, vs_o, active_o SHALL equal hs, vs, active delayed by exactly 2 clocks, aligned with pix_rgb.
REQ-026 pix_rgb SHALL read 8'h00 whenever active_o is 0.
REQ-027 wr_ready SHALL equal !fetch_slot && (!wr_vblank_only || y >= 480).
REQ-028 A write transfers at an edge where wr_valid && wr_ready; display fetch always has priority, no write transfers in a fetch slot.
REQ-029 Following a transfer with wr_addr < FB_W*FB_H, the next cycle SHALL drive mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
REQ-030 A transfer with wr_addr >= FB_W*FB_H SHALL be accepted, produce no RAM access, and increment wr_drop_cnt, saturating at 255.
REQ-031 In cycles with neither a fetch nor a write, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata hold.
REQ-032 frame_tick SHALL pulse for one cycle on the cycle after vs is sampled falling (1 to 0).
REQ-033 Back-to-back writes SHALL sustain one per clock outside fetch slots, i.e. 3 of every 4 active clocks and every blanking clock.

Reset
REQ-034 While rst_n=0: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_rgb=0, hs_o=1, vs_o=1, active_o=0, frame_tick=0, wr_drop_cnt=0, vs history=1.
REQ-035 wr_ready SHALL be 0 while rst_n=0.
REQ-036 A write transferred on the edge coinciding with reset assertion SHALL be discarded, with no RAM access after reset.
REQ-037 Operation SHALL resume on the first rising edge after deassertion with no spurious frame_tick.

Verification
REQ-038 Reset, then active=1, y=0, x=0..7 -> mem reads at addr 0 and 1 on the cycles after x=0 and x=4; pix_rgb from addr 0 for 4 clocks starting 2 clocks after x=0.
REQ-039 y=479, x=639, active=1 -> fetch at addr 19199 (the x=636 slot); active_o falls exactly 2 clocks after active.
REQ-040 wr_valid held high, wr_addr=5, active line, wr_vblank_only=0 -> wr_ready low on x%4==0 cycles; writes land only between fetches; no mem_en conflict.
REQ-041 wr_vblank_only=1, y=100 -> wr_ready=0; y=480 -> wr_ready=1, write of 8'hE3 to addr 42 appears on RAM port the next cycle.
REQ-042 300 writes to wr_addr=19200 -> no mem_we; wr_drop_cnt saturates at 255.
REQ-043 vs 1 to 0 -> single frame_tick pulse; rst_n pulsed low mid-frame -> all outputs return to their REQ-034 values immediately, no extra frame_tick.
